// File: rtl/pipe_skid_reg_if.sv
// Streaming handshake bundle around one pipeline stage: upstream beat in, downstream beat out.
// slave is the stage's view; master is the view of whatever drives and drains it.
interface pipe_skid_reg_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Valid/ready register slice with optional skid entry, sync flush, occupancy and saturating transfer count.
// Latency: one cycle in->out, no combinational in->out path; FULL_TPUT=1 gives 1 beat/cycle, FULL_TPUT=0 1 beat/2 cycles.
// Backpressure: in_ready is registered-state only (plus flush); the skid entry absorbs the beat in flight when out_ready drops.
module pipe_skid_reg #(
    parameter int DATA_W    = 32,
    parameter int FULL_TPUT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_skid_reg_if.slave       bus,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     xfer_count
);

    logic              m_v;
    logic [DATA_W-1:0] m_d;
    logic              s_v;
    logic [DATA_W-1:0] s_d;
    logic              fire_in;
    logic              fire_out;

    assign fire_in  = bus.in_valid & bus.in_ready;
    assign fire_out = m_v & bus.out_ready;

    assign bus.out_valid = m_v;
    assign bus.out_data  = m_d;
    assign occupancy     = {1'b0, m_v} + {1'b0, s_v};

    generate
        if (FULL_TPUT != 0) begin : g_skid
            // S only fills when M is busy and not draining; it always drains into M first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_v <= 1'b0;
                    s_d <= '0;
                end else if (flush) begin
                    s_v <= 1'b0;
                end else if (s_v) begin
                    if (fire_out) begin
                        s_v <= 1'b0;
                    end
                end else if (fire_in && m_v && !fire_out) begin
                    s_v <= 1'b1;
                    s_d <= bus.in_data;
                end
            end

            assign bus.in_ready = ~s_v & ~flush;
        end else begin : g_half
            assign s_v          = 1'b0;
            assign s_d          = '0;
            assign bus.in_ready = ~m_v & ~flush;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v <= 1'b0;
            m_d <= '0;
        end else if (flush) begin
            m_v <= 1'b0;
        end else if (s_v) begin
            if (fire_out) begin
                m_d <= s_d;
            end
        end else if (fire_in && (!m_v || fire_out)) begin
            m_v <= 1'b1;
            m_d <= bus.in_data;
        end else if (fire_out) begin
            m_v <= 1'b0;
        end
    end

    // A beat leaving during a flush cycle still reached the consumer, so it is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (fire_out && (xfer_count != {CNT_W{1'b1}})) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: full-rate, half-rate and narrow-counter builds side by side.
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_skid_reg_if #(.DATA_W(32)) bf ();
    pipe_skid_reg_if #(.DATA_W(32)) bh ();
    pipe_skid_reg_if #(.DATA_W(32)) bs ();

    logic        flush_f, flush_h, flush_s;
    logic [1:0]  occ_f, occ_h, occ_s;
    logic [15:0] cnt_f, cnt_h;
    logic [2:0]  cnt_s;

    pipe_skid_reg #(.DATA_W(32), .FULL_TPUT(1), .CNT_W(16)) u_full (
        .clk(clk), .rst_n(rst_n), .bus(bf), .flush(flush_f),
        .occupancy(occ_f), .xfer_count(cnt_f)
    );
    pipe_skid_reg #(.DATA_W(32), .FULL_TPUT(0), .CNT_W(16)) u_half (
        .clk(clk), .rst_n(rst_n), .bus(bh), .flush(flush_h),
        .occupancy(occ_h), .xfer_count(cnt_h)
    );
    pipe_skid_reg #(.DATA_W(32), .FULL_TPUT(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bs), .flush(flush_s),
        .occupancy(occ_s), .xfer_count(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and land 1 time unit after it, where registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bf.in_valid = 1'b0; bf.in_data = '0; bf.out_ready = 1'b0; flush_f = 1'b0;
        bh.in_valid = 1'b0; bh.in_data = '0; bh.out_ready = 1'b0; flush_h = 1'b0;
        bs.in_valid = 1'b0; bs.in_data = '0; bs.out_ready = 1'b0; flush_s = 1'b0;
        #1;
        chk("rst_out_valid", bf.out_valid, 0);
        chk("rst_out_data",  bf.out_data, 0);
        chk("rst_occ",       occ_f, 0);
        chk("rst_cnt",       cnt_f, 0);
        chk("rst_in_ready",  bf.in_ready, 1);
        chk("rst_half_in_ready", bh.in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Back-to-back stream 1..16 with out_ready held high.
        bf.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bf.in_valid = 1'b1;
            bf.in_data  = i;
            chk("stream_in_ready", bf.in_ready, 1);
            tick();
            chk("stream_out_valid", bf.out_valid, 1);
            chk("stream_out_data",  bf.out_data, i);
            chk("stream_cnt",       cnt_f, i - 1);
        end
        bf.in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", bf.out_valid, 0);
        chk("stream_cnt_final",   cnt_f, 16);
        chk("stream_occ_final",   occ_f, 0);

        // Backpressure: A, B absorbed, C held off.
        bf.out_ready = 1'b0;
        bf.in_valid = 1'b1; bf.in_data = 32'hA;
        tick();
        chk("bp_occ1",      occ_f, 1);
        chk("bp_in_ready1", bf.in_ready, 1);
        chk("bp_data_a",    bf.out_data, 32'hA);
        bf.in_data = 32'hB;
        tick();
        chk("bp_occ2",      occ_f, 2);
        chk("bp_in_ready2", bf.in_ready, 0);
        bf.in_data = 32'hC;
        tick();
        chk("bp_occ_hold",  occ_f, 2);
        chk("bp_data_hold", bf.out_data, 32'hA);
        chk("bp_valid_hold", bf.out_valid, 1);
        chk("bp_in_ready_c", bf.in_ready, 0);
        bf.out_ready = 1'b1;
        tick();
        chk("bp_rel_data_b", bf.out_data, 32'hB);
        chk("bp_rel_occ",    occ_f, 1);
        chk("bp_rel_ready",  bf.in_ready, 1);
        chk("bp_rel_cnt",    cnt_f, 17);
        tick();
        chk("bp_rel_data_c", bf.out_data, 32'hC);
        chk("bp_rel_occ_c",  occ_f, 1);
        bf.in_valid = 1'b0;
        tick();
        chk("bp_empty",      bf.out_valid, 0);
        chk("bp_cnt",        cnt_f, 19);

        // Flush with occupancy 2: A leaves and counts, D is refused.
        bf.out_ready = 1'b0;
        bf.in_valid = 1'b1; bf.in_data = 32'hA;
        tick();
        bf.in_data = 32'hB;
        tick();
        chk("fl_pre_occ", occ_f, 2);
        bf.in_data = 32'hD; bf.out_ready = 1'b1; flush_f = 1'b1;
        #1;
        chk("fl_in_ready", bf.in_ready, 0);
        tick();
        flush_f = 1'b0; bf.in_valid = 1'b0;
        chk("fl_occ",   occ_f, 0);
        chk("fl_valid", bf.out_valid, 0);
        chk("fl_cnt",   cnt_f, 20);
        tick();
        chk("fl_no_d",  bf.out_valid, 0);
        bf.out_ready = 1'b0;

        // Half-rate build: continuous offer, alternate accept/deliver.
        bh.out_ready = 1'b1;
        bh.in_valid  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bh.in_data = c / 2 + 1;
            chk("half_in_ready", bh.in_ready, (c % 2 == 0) ? 1 : 0);
            tick();
            chk("half_out_valid", bh.out_valid, (c % 2 == 0) ? 1 : 0);
            chk("half_occ",       occ_h, (c % 2 == 0) ? 1 : 0);
            if (c % 2 == 0) chk("half_out_data", bh.out_data, c / 2 + 1);
        end
        bh.in_valid = 1'b0;
        chk("half_cnt", cnt_h, 8);

        // Narrow counter saturates at 7.
        bs.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bs.in_valid = 1'b1;
            bs.in_data  = 32'h100 + i;
            tick();
            chk("sat_cnt", cnt_s, (i - 1 > 7) ? 7 : i - 1);
        end
        bs.in_valid = 1'b0;
        tick();
        chk("sat_cnt_final", cnt_s, 7);

        // Mid-cycle reset with both entries full.
        bf.out_ready = 1'b0;
        bf.in_valid = 1'b1; bf.in_data = 32'h11;
        tick();
        bf.in_data = 32'h22;
        tick();
        bf.in_valid = 1'b0;
        chk("rr_pre_occ", occ_f, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("rr_valid", bf.out_valid, 0);
        chk("rr_occ",   occ_f, 0);
        chk("rr_cnt",   cnt_f, 0);
        chk("rr_data",  bf.out_data, 0);
        #2 rst_n = 1'b1;
        #1;
        chk("rr_in_ready", bf.in_ready, 1);
        bf.out_ready = 1'b1;
        tick();
        chk("rr_idle_valid", bf.out_valid, 0);
        bf.in_valid = 1'b1; bf.in_data = 32'h55;
        tick();
        bf.in_valid = 1'b0;
        chk("rr_55_valid", bf.out_valid, 1);
        chk("rr_55_data",  bf.out_data, 32'h55);
        tick();
        chk("rr_alone",    bf.out_valid, 0);
        chk("rr_cnt_1",    cnt_f, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised valid/ready pipeline stage: a register slice between two streaming interfaces. It replaces the single-entry, half-throughput stage with a two-entry skid buffer that sustains one transfer per cycle while keeping `in_ready` registered. It also adds synchronous flush, occupancy reporting and a saturating transfer counter. A build-time mode selects the legacy half-rate behaviour for area-critical paths.

## Interface
Parameters:
- DATA_W, 32, payload width in bits (≥1)
- FULL_TPUT, 1, 1 = two-entry skid (1 beat/cycle); 0 = single-entry half-rate stage, skid entry not built
- CNT_W, 16, width of the transfer counter (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  payload of output register
- flush  in  1  synchronous discard of all held beats
- occupancy  out  2  beats held (0..2; max 1 when FULL_TPUT=0)
- xfer_count  out  CNT_W  output transfers since reset, saturating

## Operation
- State:
  - Main entry M (valid m_v, data m_d) drives `out_valid` = m_v and `out_data` = m_d.
  - Skid entry S (s_v, s_d) exists only when FULL_TPUT=1.
- Definitions: fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- `in_ready`:
  - FULL_TPUT=1: ~s_v & ~flush.
  - FULL_TPUT=0: ~m_v & ~flush.
  - Depends only on registered state and `flush`, never on `out_ready`.
- FULL_TPUT=1 update, evaluated per edge, flush excluded:
  - s_v=1: no input accepted. On fire_out: M←S, S empties.
  - s_v=0, fire_in, and (m_v=0 or fire_out): M←in_data, m_v=1.
  - s_v=0, fire_in, m_v=1, no fire_out: S←in_data, s_v=1; M held.
  - s_v=0, no fire_in, fire_out: m_v←0.
- FULL_TPUT=0 update:
  - fire_in loads M.
  - fire_out clears m_v.
  - fire_in and fire_out cannot occur together.
- Ordering: beats leave in exactly the order accepted. No beat is duplicated or dropped except by flush.
- Flush:
  - When high at an edge, m_v and s_v clear, overriding every other update.
  - `in_ready`=0 while flush is high, so no beat enters.
  - A beat on the output with out_ready=1 in the flush cycle counts as delivered and increments xfer_count.
  - Data registers need not clear.
- occupancy = m_v + s_v, registered-state derived.
- xfer_count: +1 on each fire_out, holds at 2^CNT_W−1, cleared only by reset.
- Data registers load only on their enable; they hold while invalid.

## Timing
- Reset, asynchronous, effective immediately:
  - m_v=s_v=0, m_d=s_d=0, xfer_count=0.
  - out_valid=0, out_data=0, occupancy=0.
  - in_ready=1 provided flush=0.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N. Minimum one cycle; no combinational in→out path.
- Throughput:
  - FULL_TPUT=1: one beat per cycle with out_ready held high.
  - FULL_TPUT=0: one beat per two cycles.
- Backpressure (FULL_TPUT=1): with out_ready low, a second beat is absorbed into S; `in_ready` drops the cycle after S fills. `in_ready` rises the cycle after S drains into M.
- out_valid/out_data stay stable while out_valid=1 and out_ready=0 (AXI-style hold).
- Reset asserted mid-stream discards both entries; no partial beat survives.

## Test plan
- Reset, then stream 0x1..0x10 with in_valid and out_ready held high (FULL_TPUT=1):
  - output is 0x1..0x10 in order, back-to-back;
  - first out_valid one cycle after first accept;
  - xfer_count=16;
  - in_ready never drops.
- Send 0xA, 0xB with out_ready=0, then 0xC offered:
  - occupancy goes 1→2;
  - in_ready=0 with 0xC pending, out_data stays 0xA.
  - Release out_ready: outputs are 0xA, 0xB, 0xC in order.
- Occupancy=2, then pulse flush one cycle with out_ready=1 and in_valid=1 (0xD):
  - 0xA counted as delivered;
  - next cycle occupancy=0, out_valid=0;
  - 0xD not accepted.
- FULL_TPUT=0, continuous in_valid with out_ready=1, 8 beats:
  - out_valid alternates, with 8 transfers in 16 cycles;
  - in_ready=~out_valid;
  - occupancy ≤1.
- CNT_W=3, 10 transfers: xfer_count reads 7 after the 7th transfer and stays 7.
- Assert rst_n low while occupancy=2, mid-cycle:
  - out_valid, occupancy, xfer_count go 0 immediately;
  - after release, in_ready=1 and the next beat 0x55 emerges alone.
